// File: rtl/bnn_pkg.sv
// Shared constants and FSM state encoding for the BNN accelerator stages.
// The fc1 datapath and the argmax output stage both import this package.
package bnn_pkg;

    localparam int NUM_CLASS = 10;
    localparam int SCORE_W   = 7;
    localparam int LABEL_W   = 4;
    localparam int OUT_BEATS = 2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT_HI = 2'd1,
        EMIT_LO = 2'd2
    } state_t;

endpackage

// File: rtl/bnn_max_track.sv
// Running-maximum tracker: holds the best score seen so far and its class index.
// win_idx is the winner once the score currently on score_in is included.
module bnn_max_track
    import bnn_pkg::*;
#(
    parameter int SCORE_W_P = SCORE_W,
    parameter int LABEL_W_P = LABEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 first,
    input  logic [SCORE_W_P-1:0] score_in,
    input  logic [LABEL_W_P-1:0] idx,
    output logic [SCORE_W_P-1:0] max_score,
    output logic [LABEL_W_P-1:0] max_idx,
    output logic [LABEL_W_P-1:0] win_idx
);

    logic take;

    // Strict compare: an equal later score never displaces the lower index.
    assign take    = first || (score_in > max_score);
    assign win_idx = take ? idx : max_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_score <= '0;
            max_idx   <= '0;
        end else if (en && take) begin
            max_score <= score_in;
            max_idx   <= idx;
        end
    end

endmodule

// File: rtl/bnn_argmax_out.sv
// BNN output stage: collects NUM_CLASS scores, picks the argmax and sends the
// 4-bit label off-chip as two 2-bit beats on consecutive cycles, high half first.
module bnn_argmax_out
    import bnn_pkg::*;
#(
    parameter int NUM_CLASS_P = NUM_CLASS,
    parameter int SCORE_W_P   = SCORE_W,
    parameter int LABEL_W_P   = LABEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 score_valid,
    input  logic [SCORE_W_P-1:0] score_in,
    output logic                 score_ready,
    output logic                 out_en,
    output logic [1:0]           data_out,
    output logic [1:0]           fsm_state
);

    state_t               state;
    logic [LABEL_W_P-1:0] cls_idx;
    logic [LABEL_W_P-1:0] label;
    logic [SCORE_W_P-1:0] max_score;
    logic [LABEL_W_P-1:0] max_idx;
    logic [LABEL_W_P-1:0] win_idx;
    logic                 accept;
    logic                 last;

    assign accept    = score_valid && score_ready;
    assign last      = (cls_idx == LABEL_W_P'(NUM_CLASS_P - 1));
    assign fsm_state = state;

    bnn_max_track #(
        .SCORE_W_P(SCORE_W_P),
        .LABEL_W_P(LABEL_W_P)
    ) u_max_track (
        .clk      (clk),
        .rst      (rst),
        .en       (accept),
        .first    (cls_idx == '0),
        .score_in (score_in),
        .idx      (cls_idx),
        .max_score(max_score),
        .max_idx  (max_idx),
        .win_idx  (win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            score_ready <= 1'b0;
            out_en      <= 1'b0;
            data_out    <= 2'b00;
            cls_idx     <= '0;
            label       <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    score_ready <= 1'b1;
                    out_en      <= 1'b0;
                    data_out    <= 2'b00;
                    if (accept) begin
                        if (last) begin
                            // The high beat is presented straight from the
                            // winner so it appears the cycle after the last accept.
                            label       <= win_idx;
                            cls_idx     <= '0;
                            state       <= EMIT_HI;
                            score_ready <= 1'b0;
                            out_en      <= 1'b1;
                            data_out    <= win_idx[LABEL_W_P-1 -: 2];
                        end else begin
                            cls_idx <= cls_idx + LABEL_W_P'(1);
                        end
                    end
                end
                EMIT_HI: begin
                    out_en   <= 1'b1;
                    data_out <= label[1:0];
                    state    <= EMIT_LO;
                end
                EMIT_LO: begin
                    out_en      <= 1'b0;
                    data_out    <= 2'b00;
                    score_ready <= 1'b1;
                    state       <= COLLECT;
                end
                default: begin
                    state       <= COLLECT;
                    score_ready <= 1'b0;
                    out_en      <= 1'b0;
                    data_out    <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_argmax_out.sv
// Directed testbench for bnn_argmax_out: label beats, ties, gaps, reset aborts
// and back-to-back image throughput.
module tb_bnn_argmax_out;

    logic       clk;
    logic       rst;
    logic       score_valid;
    logic [6:0] score_in;
    logic       score_ready;
    logic       out_en;
    logic [1:0] data_out;
    logic [1:0] fsm_state;

    int tests_run;
    int tests_failed;
    int cyc;
    int ready_low;

    logic [1:0] beat_q[$];
    int         beat_cyc_q[$];
    logic [3:0] exp_q[$];

    bnn_argmax_out dut (
        .clk        (clk),
        .rst        (rst),
        .score_valid(score_valid),
        .score_in   (score_in),
        .score_ready(score_ready),
        .out_en     (out_en),
        .data_out   (data_out),
        .fsm_state  (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat capture, sampled on the falling edge
    always @(negedge clk) begin
        if (out_en) begin
            beat_q.push_back(data_out);
            beat_cyc_q.push_back(cyc);
        end
        if (!score_ready) ready_low <= ready_low + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver: offers scores 0..n-1; returns right after the accepting edge of the last one.
    task automatic drive_image(input logic [6:0] sc[10], input int n, input bit gaps,
                               output bit to);
        int  budget;
        bit  acc;
        logic r;
        to = 1'b0;
        budget = 0;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                if (gaps && $urandom_range(0, 2) == 0) begin
                    score_valid = 1'b0;
                    score_in    = 7'd127;
                end else begin
                    score_valid = 1'b1;
                    score_in    = sc[i];
                end
                r = score_ready;
                @(posedge clk);
                if (score_valid && r) acc = 1'b1;
                budget++;
                if (budget > 400) begin
                    to = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        score_valid = 1'b0;
        score_in = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (score_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0", score_ready); end
        tests_run++;
        if (out_en !== 1'b0) begin tests_failed++; $display("FAIL reset_out_en got=%b exp=0", out_en); end
        tests_run++;
        if (data_out !== 2'b00) begin tests_failed++; $display("FAIL reset_data got=%b exp=00", data_out); end
        tests_run++;
        if (fsm_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (score_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_reset got=%b exp=1", score_ready); end
    endtask

    task automatic test_single_image;
        logic [6:0] img[10];
        bit to;
        img = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60, 7'd70, 7'd90, 7'd80, 7'd5};
        drive_image(img, 10, 1'b0, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL single_timeout got=%b exp=0", to); end
        @(negedge clk);
        score_valid = 1'b0;
        tests_run++;
        if ({out_en, data_out, score_ready} !== 4'b1010)
            begin tests_failed++; $display("FAIL single_hi_beat got en=%b d=%b rdy=%b exp en=1 d=01 rdy=0", out_en, data_out, score_ready); end
        @(negedge clk);
        tests_run++;
        if ({out_en, data_out, score_ready} !== 4'b1110)
            begin tests_failed++; $display("FAIL single_lo_beat got en=%b d=%b rdy=%b exp en=1 d=11 rdy=0", out_en, data_out, score_ready); end
        @(negedge clk);
        tests_run++;
        if ({out_en, score_ready} !== 2'b01)
            begin tests_failed++; $display("FAIL single_after got en=%b rdy=%b exp en=0 rdy=1", out_en, score_ready); end
        repeat (2) @(negedge clk);
        beat_q.delete();
        beat_cyc_q.delete();
    endtask

    task automatic test_tie;
        logic [6:0] img[10];
        bit to;
        beat_q.delete();
        img = '{7'd10, 7'd10, 7'd50, 7'd10, 7'd10, 7'd50, 7'd10, 7'd10, 7'd10, 7'd10};
        drive_image(img, 10, 1'b0, to);
        @(negedge clk);
        score_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (beat_q.size() !== 2) begin
            tests_failed++; $display("FAIL tie_beats got=%0d exp=2", beat_q.size());
        end else if ({beat_q[0], beat_q[1]} !== 4'b0010) begin
            tests_failed++; $display("FAIL tie_label got=%b exp=0010", {beat_q[0], beat_q[1]});
        end
        beat_q.delete();
    endtask

    task automatic test_zero_last_wins;
        logic [6:0] img[10];
        bit to;
        beat_q.delete();
        img = '{default: 7'd0};
        drive_image(img, 10, 1'b0, to);
        @(negedge clk);
        score_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (beat_q.size() !== 2) begin
            tests_failed++; $display("FAIL zero_beats got=%0d exp=2", beat_q.size());
        end else if ({beat_q[0], beat_q[1]} !== 4'b0000) begin
            tests_failed++; $display("FAIL zero_label got=%b exp=0000", {beat_q[0], beat_q[1]});
        end
        beat_q.delete();
        img = '{7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd96};
        drive_image(img, 10, 1'b0, to);
        @(negedge clk);
        score_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (beat_q.size() !== 2) begin
            tests_failed++; $display("FAIL last_beats got=%0d exp=2", beat_q.size());
        end else if ({beat_q[0], beat_q[1]} !== 4'b1001) begin
            tests_failed++; $display("FAIL last_label got=%b exp=1001", {beat_q[0], beat_q[1]});
        end
        beat_q.delete();
    endtask

    task automatic test_gaps;
        logic [6:0] img[10];
        bit to;
        beat_q.delete();
        img = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60, 7'd70, 7'd90, 7'd80, 7'd5};
        for (int k = 0; k < 3; k++) begin
            drive_image(img, 10, 1'b1, to);
            @(negedge clk);
            score_valid = 1'b0;
            score_in = 7'd127;
            repeat (3) @(negedge clk);
            tests_run++;
            if (beat_q.size() !== 2) begin
                tests_failed++; $display("FAIL gaps_beats run=%0d got=%0d exp=2", k, beat_q.size());
            end else if ({beat_q[0], beat_q[1]} !== 4'b0111) begin
                tests_failed++; $display("FAIL gaps_label run=%0d got=%b exp=0111", k, {beat_q[0], beat_q[1]});
            end
            beat_q.delete();
        end
    endtask

    task automatic test_reset_mid_collect;
        logic [6:0] img[10];
        bit to;
        beat_q.delete();
        img = '{7'd90, 7'd91, 7'd92, 7'd93, 7'd10, 7'd10, 7'd10, 7'd10, 7'd10, 7'd10};
        drive_image(img, 4, 1'b0, to);
        @(negedge clk);
        rst = 1'b1;
        score_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        tests_run++;
        if (beat_q.size() !== 0) begin tests_failed++; $display("FAIL abort_no_beats got=%0d exp=0", beat_q.size()); end
        img = '{7'd3, 7'd4, 7'd9, 7'd1, 7'd0, 7'd2, 7'd8, 7'd7, 7'd6, 7'd5};
        drive_image(img, 10, 1'b0, to);
        @(negedge clk);
        score_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (beat_q.size() !== 2) begin
            tests_failed++; $display("FAIL abort_next_beats got=%0d exp=2", beat_q.size());
        end else if ({beat_q[0], beat_q[1]} !== 4'b0010) begin
            tests_failed++; $display("FAIL abort_next_label got=%b exp=0010", {beat_q[0], beat_q[1]});
        end
        beat_q.delete();
    endtask

    task automatic test_reset_mid_emit;
        logic [6:0] img[10];
        bit to;
        beat_q.delete();
        img = '{7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd96};
        drive_image(img, 10, 1'b0, to);
        @(negedge clk);
        tests_run++;
        if ({out_en, data_out} !== 3'b110)
            begin tests_failed++; $display("FAIL emit_hi got en=%b d=%b exp en=1 d=10", out_en, data_out); end
        rst = 1'b1;
        score_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({out_en, data_out, score_ready} !== 4'b0000)
            begin tests_failed++; $display("FAIL emit_abort got en=%b d=%b rdy=%b exp all 0", out_en, data_out, score_ready); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (beat_q.size() !== 1) begin tests_failed++; $display("FAIL emit_abort_beats got=%0d exp=1", beat_q.size()); end
        beat_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [6:0] img[10];
        logic [6:0] best;
        logic [3:0] lbl;
        logic [3:0] got;
        bit to;
        bit any_to;
        int n_img;
        n_img = 100;
        any_to = 1'b0;
        beat_q.delete();
        beat_cyc_q.delete();
        exp_q.delete();
        @(negedge clk);
        ready_low = 0;
        for (int k = 0; k < n_img; k++) begin
            for (int i = 0; i < 10; i++) img[i] = 7'($urandom_range(0, 96));
            best = img[0];
            lbl = 4'd0;
            for (int i = 1; i < 10; i++) begin
                if (img[i] > best) begin
                    best = img[i];
                    lbl = 4'(i);
                end
            end
            exp_q.push_back(lbl);
            drive_image(img, 10, 1'b0, to);
            if (to) any_to = 1'b1;
        end
        @(negedge clk);
        score_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (any_to !== 1'b0) begin tests_failed++; $display("FAIL b2b_timeout got=%b exp=0", any_to); end
        tests_run++;
        if (beat_q.size() !== 2 * n_img) begin
            tests_failed++; $display("FAIL b2b_beats got=%0d exp=%0d", beat_q.size(), 2 * n_img);
        end else begin
            for (int k = 0; k < n_img; k++) begin
                got = {beat_q[2*k], beat_q[2*k+1]};
                tests_run++;
                if (got !== exp_q[k]) begin
                    tests_failed++; $display("FAIL b2b_label img=%0d got=%0d exp=%0d", k, got, exp_q[k]);
                end
                tests_run++;
                if (beat_cyc_q[2*k+1] - beat_cyc_q[2*k] !== 1) begin
                    tests_failed++; $display("FAIL b2b_beat_gap img=%0d got=%0d exp=1", k, beat_cyc_q[2*k+1] - beat_cyc_q[2*k]);
                end
                if (k > 0) begin
                    tests_run++;
                    if (beat_cyc_q[2*k] - beat_cyc_q[2*k-2] !== 12) begin
                        tests_failed++; $display("FAIL b2b_period img=%0d got=%0d exp=12", k, beat_cyc_q[2*k] - beat_cyc_q[2*k-2]);
                    end
                end
            end
        end
        tests_run++;
        if (ready_low !== 2 * n_img) begin
            tests_failed++; $display("FAIL b2b_ready_low got=%0d exp=%0d", ready_low, 2 * n_img);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        cyc = 0;
        ready_low = 0;
        rst = 1'b1;
        score_valid = 1'b0;
        score_in = 7'd0;
        test_reset();
        test_single_image();
        test_tie();
        test_zero_last_wins();
        test_gaps();
        test_reset_mid_collect();
        test_reset_mid_emit();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
